// File: rtl/toggle_line_decoder_if.sv
// Word-side handshake bundle for the toggle line decoder.
// The decoder drives the word and flags; the consumer drives word_ready.
interface toggle_line_decoder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             overrun;

  modport master (
    output word_out,
    output word_valid,
    output overrun,
    input  word_ready
  );

  modport slave (
    input  word_out,
    input  word_valid,
    input  overrun,
    output word_ready
  );
endinterface

// File: rtl/toggle_line_decoder.sv
// Recovers toggle bits from a level line: a level change since the previous strobe is a 1.
// Bits are packed MSB-first into words and handed out through a one-deep valid/ready buffer.
module toggle_line_decoder #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     line_in,
  input  logic                     line_en,
  output logic                     t_out,
  output logic                     t_valid,
  output logic [$clog2(WIDTH)-1:0] bit_count,
  toggle_line_decoder_if.master    word_bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  logic             prev_level;
  logic [WIDTH-2:0] shift;
  logic             t;
  logic             completes;
  logic [WIDTH-1:0] new_word;

  assign t         = line_in ^ prev_level;
  assign new_word  = {shift, t};
  assign completes = line_en && (bit_count == CW'(WIDTH - 1));

  assign word_bus.word_valid = (state == FULL);

  // A completed word only replaces word_out when the buffer is empty or is being drained on this edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      prev_level        <= IDLE_LEVEL;
      t_out             <= 1'b0;
      t_valid           <= 1'b0;
      shift             <= '0;
      bit_count         <= '0;
      state             <= EMPTY;
      word_bus.word_out <= '0;
      word_bus.overrun  <= 1'b0;
    end else begin
      t_valid <= line_en;
      if (line_en) begin
        prev_level <= line_in;
        t_out      <= t;
        shift      <= new_word[WIDTH-2:0];
        bit_count  <= completes ? '0 : bit_count + 1'b1;
      end
      case (state)
        EMPTY: begin
          if (completes) begin
            state             <= FULL;
            word_bus.word_out <= new_word;
          end
        end
        FULL: begin
          if (completes) begin
            if (word_bus.word_ready) begin
              word_bus.word_out <= new_word;
            end else begin
              word_bus.overrun <= 1'b1;
            end
          end else if (word_bus.word_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_line_decoder.sv
// Directed bench for toggle_line_decoder; expected toggle bits and words go into queues
// that a negedge monitor pops whenever the decoder presents a bit or a fresh word.
module tb_toggle_line_decoder;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       line_in;
  logic       line_en;
  logic       t_out;
  logic       t_valid;
  logic [2:0] bit_count;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] word_exp[$];
  logic             t_exp[$];
  logic             prev_valid = 1'b0;
  logic             prev_take  = 1'b0;

  toggle_line_decoder_if #(.WIDTH(WIDTH)) bus ();

  toggle_line_decoder #(.WIDTH(WIDTH), .IDLE_LEVEL(1'b0)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .line_in   (line_in),
    .line_en   (line_en),
    .t_out     (t_out),
    .t_valid   (t_valid),
    .bit_count (bit_count),
    .word_bus  (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A fresh word is on the bus when valid rises or when the previous one was taken while still valid.
  always @(negedge clk) begin
    if (t_valid) begin
      if (t_exp.size() == 0) begin
        check_output("t_unexpected", 32'd1, 32'd0);
      end else begin
        check_output("t_out", {31'd0, t_out}, {31'd0, t_exp.pop_front()});
      end
    end
    if (bus.word_valid && (!prev_valid || prev_take)) begin
      if (word_exp.size() == 0) begin
        check_output("word_unexpected", 32'd1, 32'd0);
      end else begin
        check_output("word_out", {24'd0, bus.word_out}, {24'd0, word_exp.pop_front()});
      end
    end
    prev_take  = bus.word_valid && bus.word_ready;
    prev_valid = bus.word_valid;
  end

  task automatic apply_stimulus(input logic lvl, input logic en);
    line_in = lvl;
    line_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] lv, input int n, input logic [7:0] tv, input logic rdy_last);
    for (int i = 0; i < n; i++) begin
      t_exp.push_back(tv[7-i]);
      if (rdy_last && i == n - 1) bus.word_ready = 1'b1;
      apply_stimulus(lv[7-i], 1'b1);
    end
    line_en = 1'b0;
  endtask

  task automatic send_gapped(input logic [7:0] lv, input logic [7:0] tv);
    for (int i = 0; i < 8; i++) begin
      t_exp.push_back(tv[7-i]);
      apply_stimulus(lv[7-i], 1'b1);
      apply_stimulus(~lv[7-i], 1'b0);
      apply_stimulus((i < 7) ? lv[6-i] : lv[0], 1'b0);
    end
  endtask

  task automatic do_reset();
    #1 clr_n = 1'b0;
    @(posedge clk);
    #1 clr_n = 1'b1;
  endtask

  initial begin
    clr_n          = 1'b0;
    line_in        = 1'b0;
    line_en        = 1'b0;
    bus.word_ready = 1'b1;
    @(posedge clk);
    #1 clr_n = 1'b1;

    check_output("rst_t_out", {31'd0, t_out}, 32'd0);
    check_output("rst_t_valid", {31'd0, t_valid}, 32'd0);
    check_output("rst_word_out", {24'd0, bus.word_out}, 32'd0);
    check_output("rst_word_valid", {31'd0, bus.word_valid}, 32'd0);
    check_output("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    check_output("rst_bit_count", {29'd0, bit_count}, 32'd0);

    // Decode word: line 1,1,0,0,0,1,0,1 -> toggles 1,0,1,0,0,1,1,1 = A7
    word_exp.push_back(8'hA7);
    send_bits(8'hC5, 8, 8'hA7, 1'b0);
    check_output("a_word_valid", {31'd0, bus.word_valid}, 32'd1);
    check_output("a_bit_count", {29'd0, bit_count}, 32'd0);
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0);

    // Constant levels: all-zero line gives 00, all-one line toggles only on the first sample
    do_reset();
    word_exp.push_back(8'h00);
    send_bits(8'h00, 8, 8'h00, 1'b0);
    apply_stimulus(1'b0, 1'b0);
    do_reset();
    word_exp.push_back(8'h80);
    send_bits(8'hFF, 8, 8'h80, 1'b0);
    apply_stimulus(1'b1, 1'b0);

    // Overrun: A7 held with ready low while two more words complete and are dropped
    do_reset();
    bus.word_ready = 1'b0;
    word_exp.push_back(8'hA7);
    send_bits(8'hC5, 8, 8'hA7, 1'b0);
    send_bits(8'hFF, 8, 8'h00, 1'b0);
    send_bits(8'hFF, 8, 8'h00, 1'b0);
    check_output("c_word_out", {24'd0, bus.word_out}, 32'hA7);
    check_output("c_word_valid", {31'd0, bus.word_valid}, 32'd1);
    check_output("c_overrun", {31'd0, bus.overrun}, 32'd1);
    bus.word_ready = 1'b1;
    apply_stimulus(1'b1, 1'b0);
    bus.word_ready = 1'b0;
    check_output("c_drained_valid", {31'd0, bus.word_valid}, 32'd0);
    check_output("c_overrun_sticky", {31'd0, bus.overrun}, 32'd1);
    apply_stimulus(1'b1, 1'b0);
    check_output("c_overrun_still", {31'd0, bus.overrun}, 32'd1);
    do_reset();
    check_output("c_overrun_cleared", {31'd0, bus.overrun}, 32'd0);

    // Second word completes on the same edge that accepts the first
    bus.word_ready = 1'b0;
    word_exp.push_back(8'h00);
    send_bits(8'h00, 8, 8'h00, 1'b0);
    word_exp.push_back(8'h08);
    send_bits(8'h0F, 8, 8'h08, 1'b1);
    check_output("d_word_valid", {31'd0, bus.word_valid}, 32'd1);
    check_output("d_overrun", {31'd0, bus.overrun}, 32'd0);
    apply_stimulus(1'b1, 1'b0);
    check_output("d_drained_valid", {31'd0, bus.word_valid}, 32'd0);

    // Async clear mid-word, between clock edges; prev level was 1 so line 1,0,1 toggles 0,1,1
    send_bits(8'hA0, 3, 8'h60, 1'b0);
    check_output("e_bit_count_mid", {29'd0, bit_count}, 32'd3);
    #6 clr_n = 1'b0;
    #1;
    check_output("e_t_out", {31'd0, t_out}, 32'd0);
    check_output("e_t_valid", {31'd0, t_valid}, 32'd0);
    check_output("e_word_out", {24'd0, bus.word_out}, 32'd0);
    check_output("e_bit_count", {29'd0, bit_count}, 32'd0);
    #1 clr_n = 1'b1;
    @(posedge clk);
    #1;
    word_exp.push_back(8'hA7);
    send_bits(8'hC5, 8, 8'hA7, 1'b0);
    apply_stimulus(1'b1, 1'b0);

    // Gapped strobes with a double toggle between some of them
    do_reset();
    word_exp.push_back(8'hA7);
    send_gapped(8'hC5, 8'hA7);
    check_output("f_word_out", {24'd0, bus.word_out}, 32'hA7);
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0);

    check_output("t_queue_empty", t_exp.size(), 32'd0);
    check_output("word_queue_empty", word_exp.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/toggle_line_decoder.md
Name: toggle_line_decoder

Overview:
- Receive-side counterpart to the toggle-driven D storage cell: recovers the toggle stream from a level line, where a toggle means "line level differs from the previous sample".
- Sampled line transition = bit 1; no transition = bit 0.
- Decoded bits are exposed per sample and packed MSB-first into WIDTH-bit words.
- Words are delivered on a valid/ready output handshake with a sticky overrun flag.
- Sits between a toggle-encoded serial line and any word-level consumer.

Parameters:
WIDTH, 8, bits per assembled word (2..32)
IDLE_LEVEL, 1'b0, reference line level loaded at reset; the first sample is compared against it

Ports:
clk  input  1  clock; all state updates on posedge
clr_n  input  1  asynchronous active-low reset (clear)
line_in  input  1  toggle-encoded line level
line_en  input  1  sample strobe; line_in is sampled only on posedges where line_en=1
t_out  output  1  last decoded toggle bit, registered
t_valid  output  1  one-cycle pulse: t_out updated this cycle
word_out  output  WIDTH  last completed word, MSB = first received bit
word_valid  output  1  word_out holds an unconsumed word
word_ready  input  1  consumer accepts word_out when word_valid=1
overrun  output  1  sticky: a completed word was dropped
bit_count  output  $clog2(WIDTH)  bits collected in current partial word

Behaviour:
- **Async reset (clr_n=0).** Takes effect immediately, independent of clk:
  - prev_level=IDLE_LEVEL, t_out=0, t_valid=0
  - shift=0, bit_count=0
  - word_out=0, word_valid=0, overrun=0
- **Sample (posedge, line_en=1):**
  - t = line_in ^ prev_level
  - prev_level <= line_in
  - t_out <= t, t_valid <= 1
  - shift <= {shift[WIDTH-2:0], t}
- **Idle (line_en=0):**
  - prev_level, shift and bit_count hold.
  - t_valid <= 0.
  - Line changes between strobes are not counted. Only the level at the next strobe is compared, so multiple transitions between strobes collapse into one comparison.
- **Bit counting:**
  - bit_count increments per sample.
  - On the sample where bit_count==WIDTH-1, the word completes: the completed word is {shift[WIDTH-2:0], t} and bit_count wraps to 0.
- **Output FSM, two states: EMPTY (word_valid=0) and FULL (word_valid=1).**
  - EMPTY, word completes -> FULL; word_out <= completed word.
  - EMPTY, no completion -> EMPTY.
  - FULL, word_ready=1, no completion -> EMPTY; word_out holds its value.
  - FULL, word_ready=1, completion in the same cycle -> FULL; word_out <= new word; no overrun.
  - FULL, word_ready=0, completion -> FULL; new word discarded; word_out unchanged; overrun <= 1.
  - FULL, word_ready=0, no completion -> FULL; hold.
- **overrun** clears only via clr_n.
- **word_ready while EMPTY** is ignored.
- **Latency:**
  - t_out/t_valid appear on the clock edge that samples line_in, visible the following cycle.
  - word_valid rises on the edge of the WIDTH-th sample.
  - Back-to-back strobes give one word per WIDTH cycles.
- **Reset mid-word:** the partial word is lost, and the next sample is compared against IDLE_LEVEL.
- **Inputs:** no X-handling is required; inputs are assumed driven after reset release.

Test Plan:
- **Decode word.** WIDTH=8, IDLE_LEVEL=0, line_en=1 every cycle, line_in = 1,1,0,0,0,1,0,1 -> t_out sequence 1,0,1,0,0,1,1,1; word_out=8'hA7 and word_valid=1 after the 8th edge; bit_count returns to 0.
- **Constant-level words.**
  - line_in held 0 for 8 strobes after reset -> word_out=8'h00.
  - line_in held 1 for 8 strobes after reset -> word_out=8'h80 (only the first sample toggles).
- **Overrun.** word_ready=0; send 0xA7 then 16 further constant-level strobes -> word_out stays 8'hA7, word_valid=1, overrun=1 after the 16th edge. Overrun stays 1 after word_ready pulses, and is cleared only by clr_n.
- **Simultaneous accept and complete.** Second word completes on the same edge as word_ready=1 -> word_valid stays 1, word_out = second word, overrun=0.
- **Async reset mid-word.** After 3 samples, pulse clr_n low between clock edges -> all outputs 0 immediately, with no clock needed. The next 8 strobes produce a full word, decoded against IDLE_LEVEL.
- **Gapped strobes.** line_en high every 3rd cycle; line_in toggles twice between strobes -> t=0 for that strobe; word assembly is otherwise identical to the back-to-back case.
